// File: rtl/rtsnoc_pkg.sv
// rtsnoc_pkg: shared RTSNoC flit geometry, field offsets and ping FSM states
package rtsnoc_pkg;
  localparam int LOCAL_W = 3;
  localparam int FLIT_W = 38;
  localparam int DEF_SOC_SIZE_X = 1;
  localparam int DEF_SOC_SIZE_Y = 1;
  localparam int DEF_DATA_W = 16;
  localparam int SOC_XY_SIZE = DEF_SOC_SIZE_X + DEF_SOC_SIZE_Y;
  localparam int NOC_HEADER_SIZE = 2 * SOC_XY_SIZE + 2 * LOCAL_W;
  localparam int NOC_BUS_SIZE = NOC_HEADER_SIZE + DEF_DATA_W;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND_WAIT,
    ST_SEND,
    ST_RECV,
    ST_CHECK,
    ST_DONE
  } ping_state_e;
  function automatic int header_size(input int sx, input int sy);
    return 2 * (sx + sy + LOCAL_W);
  endfunction
  function automatic int off_l_dst(input int dw);
    return dw;
  endfunction
  function automatic int off_y_dst(input int dw);
    return dw + LOCAL_W;
  endfunction
  function automatic int off_x_dst(input int dw, input int sy);
    return dw + LOCAL_W + sy;
  endfunction
  function automatic int off_l_orig(input int dw, input int sx, input int sy);
    return dw + LOCAL_W + sx + sy;
  endfunction
  function automatic int off_y_orig(input int dw, input int sx, input int sy);
    return dw + 2 * LOCAL_W + sx + sy;
  endfunction
  function automatic int off_x_orig(input int dw, input int sx, input int sy);
    return dw + 2 * LOCAL_W + sx + 2 * sy;
  endfunction
endpackage

// File: rtl/rtsnoc_flit_codec.sv
// rtsnoc_flit_codec: packs header fields plus data into a router flit and unpacks a received flit
module rtsnoc_flit_codec
  import rtsnoc_pkg::*;
#(
  parameter int SX = DEF_SOC_SIZE_X,
  parameter int SY = DEF_SOC_SIZE_Y,
  parameter int DW = DEF_DATA_W
) (
  input  logic [SX-1:0]      tx_x_orig,
  input  logic [SY-1:0]      tx_y_orig,
  input  logic [LOCAL_W-1:0] tx_l_orig,
  input  logic [SX-1:0]      tx_x_dst,
  input  logic [SY-1:0]      tx_y_dst,
  input  logic [LOCAL_W-1:0] tx_l_dst,
  input  logic [DW-1:0]      tx_data,
  output logic [FLIT_W-1:0]  tx_flit,
  input  logic [FLIT_W-1:0]  rx_flit,
  output logic [SX-1:0]      rx_x_orig,
  output logic [SY-1:0]      rx_y_orig,
  output logic [LOCAL_W-1:0] rx_l_orig,
  output logic [SX-1:0]      rx_x_dst,
  output logic [SY-1:0]      rx_y_dst,
  output logic [LOCAL_W-1:0] rx_l_dst,
  output logic [DW-1:0]      rx_data
);
  localparam int BUS = header_size(SX, SY) + DW;
  logic [BUS-1:0] rx_bus;
  logic unused_hi;
  // bits above the bus are driven zero on transmit and ignored on receive
  assign tx_flit = FLIT_W'({tx_x_orig, tx_y_orig, tx_l_orig, tx_x_dst, tx_y_dst, tx_l_dst, tx_data});
  assign rx_bus = rx_flit[BUS-1:0];
  assign unused_hi = ^(rx_flit >> BUS);
  assign rx_data = rx_bus[DW-1:0];
  assign rx_l_dst = rx_bus[off_l_dst(DW) +: LOCAL_W];
  assign rx_y_dst = rx_bus[off_y_dst(DW) +: SY];
  assign rx_x_dst = rx_bus[off_x_dst(DW, SY) +: SX];
  assign rx_l_orig = rx_bus[off_l_orig(DW, SX, SY) +: LOCAL_W];
  assign rx_y_orig = rx_bus[off_y_orig(DW, SX, SY) +: SY];
  assign rx_x_orig = rx_bus[off_x_orig(DW, SX, SY) +: SX];
endmodule

// File: rtl/rtsnoc_ping_sm.sv
// rtsnoc_ping_sm: sends a burst of sequence-numbered packets to an echo node and checks each reply
module rtsnoc_ping_sm
  import rtsnoc_pkg::*;
#(
  parameter int TX_ADDR = 0,
  parameter int TX_ADDR_X = 0,
  parameter int TX_ADDR_Y = 0,
  parameter int DST_ADDR = 1,
  parameter int DST_ADDR_X = 0,
  parameter int DST_ADDR_Y = 0,
  parameter int SOC_SIZE_X = DEF_SOC_SIZE_X,
  parameter int SOC_SIZE_Y = DEF_SOC_SIZE_Y,
  parameter int NOC_DATA_WIDTH = DEF_DATA_W,
  parameter logic [NOC_DATA_WIDTH-1:0] PATTERN = NOC_DATA_WIDTH'(16'hA5C3),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [15:0]       count_i,
  output logic [FLIT_W-1:0] din_o,
  output logic              wr_o,
  output logic              rd_o,
  input  logic [FLIT_W-1:0] dout_i,
  input  logic              wait_i,
  input  logic              nd_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [15:0]       sent_o,
  output logic [15:0]       ok_o,
  output logic [15:0]       err_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SOC_SIZE_X-1:0] OWN_X = SOC_SIZE_X'(TX_ADDR_X);
  localparam logic [SOC_SIZE_Y-1:0] OWN_Y = SOC_SIZE_Y'(TX_ADDR_Y);
  localparam logic [LOCAL_W-1:0] OWN_L = LOCAL_W'(TX_ADDR);
  localparam logic [SOC_SIZE_X-1:0] DST_X = SOC_SIZE_X'(DST_ADDR_X);
  localparam logic [SOC_SIZE_Y-1:0] DST_Y = SOC_SIZE_Y'(DST_ADDR_Y);
  localparam logic [LOCAL_W-1:0] DST_L = LOCAL_W'(DST_ADDR);
  ping_state_e state, state_n;
  logic [15:0] cnt, seq;
  logic [TW-1:0] tcnt;
  logic [FLIT_W-1:0] cap, tx_flit;
  logic [NOC_DATA_WIDTH-1:0] tx_data, rx_data;
  logic [SOC_SIZE_X-1:0] rx_x_orig, rx_x_dst;
  logic [SOC_SIZE_Y-1:0] rx_y_orig, rx_y_dst;
  logic [LOCAL_W-1:0] rx_l_orig, rx_l_dst;
  logic idle, match, tmo, last;
  rtsnoc_flit_codec #(
    .SX(SOC_SIZE_X),
    .SY(SOC_SIZE_Y),
    .DW(NOC_DATA_WIDTH)
  ) u_codec (
    .tx_x_orig(OWN_X),
    .tx_y_orig(OWN_Y),
    .tx_l_orig(OWN_L),
    .tx_x_dst (DST_X),
    .tx_y_dst (DST_Y),
    .tx_l_dst (DST_L),
    .tx_data  (tx_data),
    .tx_flit  (tx_flit),
    .rx_flit  (cap),
    .rx_x_orig(rx_x_orig),
    .rx_y_orig(rx_y_orig),
    .rx_l_orig(rx_l_orig),
    .rx_x_dst (rx_x_dst),
    .rx_y_dst (rx_y_dst),
    .rx_l_dst (rx_l_dst),
    .rx_data  (rx_data)
  );
  // seq is held until CHECK, so tx_data is still the value that was sent
  assign tx_data = NOC_DATA_WIDTH'(seq) ^ PATTERN;
  assign match = rx_data == tx_data && rx_x_orig == DST_X && rx_y_orig == DST_Y && rx_l_orig == DST_L
              && rx_x_dst == OWN_X && rx_y_dst == OWN_Y && rx_l_dst == OWN_L;
  assign tmo = tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign last = sent_o == cnt;
  assign idle = state == ST_IDLE || state == ST_DONE;
  assign busy_o = !idle;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE, ST_DONE: state_n = start_i ? (count_i == 16'd0 ? ST_DONE : ST_LOAD) : state;
      ST_LOAD: state_n = ST_SEND_WAIT;
      ST_SEND_WAIT: state_n = wait_i ? ST_SEND_WAIT : ST_SEND;
      ST_SEND: state_n = ST_RECV;
      ST_RECV: state_n = nd_i ? ST_CHECK : (tmo ? ST_DONE : ST_RECV);
      ST_CHECK: state_n = last ? ST_DONE : ST_LOAD;
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
      seq <= '0;
      tcnt <= '0;
      cap <= '0;
      din_o <= '0;
      wr_o <= 1'b0;
      rd_o <= 1'b0;
      done_o <= 1'b0;
      pass_o <= 1'b0;
      timeout_o <= 1'b0;
      sent_o <= '0;
      ok_o <= '0;
      err_o <= '0;
    end else begin
      wr_o <= state == ST_SEND_WAIT && !wait_i;
      rd_o <= state == ST_RECV && nd_i;
      if (idle && start_i) begin
        cnt <= count_i;
        seq <= '0;
        sent_o <= '0;
        ok_o <= '0;
        err_o <= '0;
        timeout_o <= 1'b0;
        done_o <= count_i == 16'd0;
        pass_o <= count_i == 16'd0;
      end
      if (state == ST_LOAD) din_o <= tx_flit;
      if (state == ST_SEND) begin
        sent_o <= sent_o + 16'd1;
        tcnt <= '0;
      end
      if (state == ST_RECV) begin
        if (nd_i) cap <= dout_i;
        else begin
          tcnt <= tcnt + TW'(1);
          if (tmo) begin
            timeout_o <= 1'b1;
            err_o <= err_o + 16'd1;
            done_o <= 1'b1;
            pass_o <= 1'b0;
          end
        end
      end
      if (state == ST_CHECK) begin
        ok_o <= ok_o + 16'(match);
        err_o <= err_o + 16'(!match);
        seq <= seq + 16'd1;
        if (last) begin
          done_o <= 1'b1;
          pass_o <= match && err_o == 16'd0 && !timeout_o;
        end
      end
    end
  end
endmodule

// File: tb/tb_rtsnoc_ping_sm.sv
// tb_rtsnoc_ping_sm: ping generator against a behavioural echo node with a per-burst outcome model
module tb_rtsnoc_ping_sm;
  import rtsnoc_pkg::*;
  localparam logic [15:0] PAT = 16'hA5C3;
  localparam logic [37:0] BUS_MASK = (38'd1 << NOC_BUS_SIZE) - 38'd1;
  logic clk_i = 1'b0;
  logic rst_i, start_i, wr_o, rd_o, wait_i, nd_i, busy_o, done_o, pass_o, timeout_o;
  logic [15:0] count_i, sent_o, ok_o, err_o;
  logic [37:0] din_o, dout_i;
  int n_chk, n_fail, cyc, wr_total, rd_total, wr_cyc, lat_min, lat_max;
  logic [37:0] cmask [16];
  bit drop [16];
  logic [37:0] masks [6];

  rtsnoc_ping_sm #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .count_i(count_i),
    .din_o(din_o), .wr_o(wr_o), .rd_o(rd_o), .dout_i(dout_i), .wait_i(wait_i), .nd_i(nd_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .sent_o(sent_o), .ok_o(ok_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // {X_orig, Y_orig, local_orig, X_dst, Y_dst, local_dst, data} with 1-bit coordinates
  function automatic logic [37:0] flit(input int xo, input int yo, input int lo, input int xd,
                                       input int yd, input int ld, input logic [15:0] d);
    return 38'(d) | (38'(ld) << 16) | (38'(yd) << 19) | (38'(xd) << 20)
         | (38'(lo) << 21) | (38'(yo) << 24) | (38'(xo) << 25);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 16; i++) begin
      cmask[i] = '0;
      drop[i] = 1'b0;
    end
  endtask

  // echo node: replies to each write with orig/dst swapped after a random delay
  initial begin : echo
    int k, dly;
    bit pend;
    logic [37:0] rep;
    nd_i = 1'b0; dout_i = '0; k = 0; dly = 0; pend = 1'b0; rep = '0;
    forever begin
      @(posedge clk_i); #1;
      if (!rst_i) begin
        nd_i = 1'b0; pend = 1'b0; k = 0;
      end else begin
        if (!busy_o) k = 0;
        if (rd_o) begin
          rd_total++;
          check("rd_needs_nd", 64'(nd_i), 64'(1));
          nd_i = 1'b0;
        end
        if (wr_o) begin
          wr_total++;
          wr_cyc = cyc;
          check("din_flit", 64'(din_o), 64'(flit(0, 0, 0, 0, 0, 1, 16'(k) ^ PAT)));
          if (!drop[k]) begin
            pend = 1'b1;
            dly = int'($urandom_range(lat_max, lat_min));
            rep = flit(0, 0, 1, 0, 0, 0, 16'(k) ^ PAT) ^ cmask[k];
          end
          k++;
        end
        if (pend) begin
          if (dly == 0) begin
            nd_i = 1'b1; dout_i = rep; pend = 1'b0;
          end else dly--;
        end
      end
    end
  end

  task automatic run_burst(input int n, input int hold, input bit bp);
    int es, eo, ee, ers, w0, r0, t;
    bit eto;
    es = 0; eo = 0; ee = 0; eto = 1'b0;
    for (int i = 0; i < n; i++) begin
      es++;
      if (drop[i]) begin
        ee++; eto = 1'b1;
        break;
      end
      if ((cmask[i] & BUS_MASK) != '0) ee++;
      else eo++;
    end
    ers = es - int'(eto);
    w0 = wr_total; r0 = rd_total;
    @(negedge clk_i);
    count_i = 16'(n); start_i = 1'b1; wait_i = hold > 0;
    @(negedge clk_i);
    start_i = 1'b0;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk_i);
        check("hold_wr", 64'(wr_o), 64'(0));
        check("hold_din", 64'(din_o), 64'(flit(0, 0, 0, 0, 0, 1, PAT)));
      end
      wait_i = 1'b0;
      @(negedge clk_i);
      check("wr_after_wait", 64'(wr_o), 64'(1));
      check("din_at_wr", 64'(din_o), 64'(flit(0, 0, 0, 0, 0, 1, PAT)));
    end
    t = 0;
    while (!done_o && t < 3000) begin
      wait_i = bp && $urandom_range(2, 0) == 0;
      @(negedge clk_i);
      t++;
    end
    wait_i = 1'b0;
    if (n == 0) check("zero_done_latency", 64'(t), 64'(0));
    check("done", 64'(done_o), 64'(1));
    check("busy", 64'(busy_o), 64'(0));
    check("sent", 64'(sent_o), 64'(es));
    check("ok", 64'(ok_o), 64'(eo));
    check("err", 64'(err_o), 64'(ee));
    check("pass", 64'(pass_o), 64'(ee == 0));
    check("timeout", 64'(timeout_o), 64'(eto));
    if (eto) check("timeout_latency", 64'(cyc - wr_cyc - 1), 64'(8));
    repeat (4) @(negedge clk_i);
    check("wr_pulses", 64'(wr_total - w0), 64'(es));
    check("rd_pulses", 64'(rd_total - r0), 64'(ers));
  endtask

  initial begin : main
    int w0, w1, r1, t, n, r;
    masks = '{38'h1, 38'h8000, 38'h10000, 38'h200000, 38'h2000000, 38'h40000000};
    rst_i = 1'b0; start_i = 1'b0; count_i = '0; wait_i = 1'b0;
    lat_min = 0; lat_max = 0;
    clear_plan();
    @(negedge clk_i);
    check("reset_flags", 64'({din_o, wr_o, rd_o, busy_o, done_o, pass_o, timeout_o}), 64'(0));
    check("reset_counts", 64'({sent_o, ok_o, err_o}), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b1;
    run_burst(4, 0, 1'b0);
    lat_max = 2;
    run_burst(3, 10, 1'b0);
    lat_max = 0;
    cmask[1] = 38'h1;
    run_burst(3, 0, 1'b0);
    clear_plan();
    drop[1] = 1'b1;
    run_burst(3, 0, 1'b0);
    clear_plan();
    run_burst(0, 0, 1'b0);
    lat_min = 3; lat_max = 3;
    w0 = wr_total;
    @(negedge clk_i);
    count_i = 16'd3; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    t = 0;
    while (wr_total < w0 + 2 && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    check("reset_reach_pkt2", 64'(wr_total - w0), 64'(2));
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check("async_reset_flags", 64'({din_o, wr_o, rd_o, busy_o, done_o, pass_o, timeout_o}), 64'(0));
    check("async_reset_counts", 64'({sent_o, ok_o, err_o}), 64'(0));
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    w1 = wr_total; r1 = rd_total;
    repeat (20) @(negedge clk_i);
    check("post_reset_wr", 64'(wr_total - w1), 64'(0));
    check("post_reset_rd", 64'(rd_total - r1), 64'(0));
    check("post_reset_busy", 64'(busy_o), 64'(0));
    lat_min = 0;
    run_burst(2, 0, 1'b1);
    repeat (8) begin
      n = int'($urandom_range(6, 1));
      clear_plan();
      for (int i = 0; i < n; i++) begin
        r = int'($urandom_range(9, 0));
        if (r == 0) drop[i] = 1'b1;
        else if (r <= 3) cmask[i] = masks[$urandom_range(5, 0)];
      end
      lat_max = int'($urandom_range(3, 0));
      run_burst(n, 0, 1'b1);
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
